// File: rtl/time_setter.sv
// User time-setting controller: edits hour/min/sec in packed BCD and
// hands the result to the clockwork with a one-cycle overwrite strobe.
module time_setter #(
    parameter logic [31:0] TIMEOUT_CYC = 32'd100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] time_cur,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_cancel,
    output logic [19:0] time_set,
    output logic        time_ow,
    output logic [19:0] time_disp,
    output logic [1:0]  edit_field
);

    typedef enum logic [2:0] {
        S_IDLE, S_HOUR, S_MIN, S_SEC, S_COMMIT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  btn_q, btn_d, prs;
    logic [19:0] edit_q, edit_d;
    logic [19:0] set_q, set_d;
    logic        ow_q, ow_d;
    logic [1:0]  field_q, field_d;
    logic [31:0] tmo_q, tmo_d;

    logic [7:0]  hr_c, mn_c, sc_c;
    logic [7:0]  fld, fmax, fld_n;
    logic [19:0] cap;
    logic [1:0]  unused_fld;
    logic        tmo_hit;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] max);
        if (v == max) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v,
                                           input logic [7:0] max);
        if (v == 8'h00) return max;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return v - 8'd1;
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v,
                                    input logic [7:0] max);
        return (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    assign btn_d = {btn_cancel, btn_mode, btn_up, btn_down};
    assign prs   = btn_d & ~btn_q;

    assign hr_c = {2'b00, time_cur[19:14]};
    assign mn_c = {1'b0, time_cur[13:7]};
    assign sc_c = {1'b0, time_cur[6:0]};
    assign cap  = {bcd_ok(hr_c, 8'h23) ? hr_c[5:0] : 6'd0,
                   bcd_ok(mn_c, 8'h59) ? mn_c[6:0] : 7'd0,
                   bcd_ok(sc_c, 8'h59) ? sc_c[6:0] : 7'd0};

    assign tmo_hit = (TIMEOUT_CYC != 32'd0) &&
                     (tmo_q == TIMEOUT_CYC - 32'd1);

    always_comb begin
        fld  = 8'h00;
        fmax = 8'h59;
        unique case (state_q)
            S_HOUR: begin
                fld  = {2'b00, edit_q[19:14]};
                fmax = 8'h23;
            end
            S_MIN:   fld = {1'b0, edit_q[13:7]};
            S_SEC:   fld = {1'b0, edit_q[6:0]};
            default: fld = 8'h00;
        endcase
        fld_n = prs[1] ? bcd_inc(fld, fmax) : bcd_dec(fld, fmax);
    end

    assign unused_fld = fld_n[7:6];

    always_comb begin
        state_d = state_q;
        edit_d  = edit_q;
        set_d   = set_q;
        ow_d    = 1'b0;
        tmo_d   = tmo_q;
        unique case (state_q)
            S_IDLE: begin
                tmo_d = 32'd0;
                if (prs[2]) begin
                    edit_d  = cap;
                    state_d = S_HOUR;
                end
            end
            S_HOUR, S_MIN, S_SEC: begin
                if (prs[3]) begin
                    state_d = S_IDLE;
                    tmo_d   = 32'd0;
                end else if (prs[2]) begin
                    tmo_d = 32'd0;
                    if (state_q == S_HOUR) begin
                        state_d = S_MIN;
                    end else if (state_q == S_MIN) begin
                        state_d = S_SEC;
                    end else begin
                        state_d = S_COMMIT;
                        set_d   = edit_q;
                        ow_d    = 1'b1;
                    end
                end else begin
                    // Up and down together cancel out.
                    if (prs[1] ^ prs[0]) begin
                        if (state_q == S_HOUR) edit_d[19:14] = fld_n[5:0];
                        else if (state_q == S_MIN) edit_d[13:7] = fld_n[6:0];
                        else edit_d[6:0] = fld_n[6:0];
                    end
                    if (|prs) begin
                        tmo_d = 32'd0;
                    end else if (tmo_hit) begin
                        tmo_d   = 32'd0;
                        state_d = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        unique case (state_d)
            S_HOUR:  field_d = 2'd1;
            S_MIN:   field_d = 2'd2;
            S_SEC:   field_d = 2'd3;
            default: field_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            btn_q   <= 4'hF;
            edit_q  <= 20'd0;
            set_q   <= 20'd0;
            ow_q    <= 1'b0;
            field_q <= 2'd0;
            tmo_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn_d;
            edit_q  <= edit_d;
            set_q   <= set_d;
            ow_q    <= ow_d;
            field_q <= field_d;
            tmo_q   <= tmo_d;
        end
    end

    assign time_set   = set_q;
    assign time_ow    = ow_q;
    assign edit_field = field_q;
    assign time_disp  = (state_q == S_IDLE) ? time_cur : edit_q;

endmodule

// File: tb/tb_time_setter.sv
// Scoreboard bench for time_setter: commits are queued as expected
// time_set values and matched when the overwrite strobe fires.
module tb_time_setter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] time_cur;
    logic        btn_mode, btn_up, btn_down, btn_cancel;
    logic [19:0] time_set, time_disp;
    logic        time_ow;
    logic [1:0]  edit_field;

    localparam logic [3:0] CAN  = 4'b1000;
    localparam logic [3:0] MODE = 4'b0100;
    localparam logic [3:0] UP   = 4'b0010;
    localparam logic [3:0] DN   = 4'b0001;

    int n_chk = 0;
    int n_pass = 0;
    int ow_cnt = 0;
    logic [19:0] sb_q[$];
    logic [19:0] last_set = 20'd0;

    time_setter #(.TIMEOUT_CYC(32'd16)) dut (
        .clk(clk), .rst_n(rst_n), .time_cur(time_cur),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .btn_cancel(btn_cancel), .time_set(time_set), .time_ow(time_ow),
        .time_disp(time_disp), .edit_field(edit_field)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [19:0] pk(input logic [7:0] h,
                                       input logic [7:0] m,
                                       input logic [7:0] s);
        return {h[5:0], m[6:0], s[6:0]};
    endfunction

    function automatic logic [7:0] hr(input logic [19:0] t);
        return {2'b00, t[19:14]};
    endfunction
    function automatic logic [7:0] mn(input logic [19:0] t);
        return {1'b0, t[13:7]};
    endfunction
    function automatic logic [7:0] sc(input logic [19:0] t);
        return {1'b0, t[6:0]};
    endfunction

    always @(negedge clk) begin
        if (rst_n && time_ow) begin
            ow_cnt++;
            if (sb_q.size() == 0) chk("ow_unexp", 1, 0);
            else chk("commit", time_set, sb_q.pop_front());
        end
    end

    task automatic drive(input logic [3:0] m);
        {btn_cancel, btn_mode, btn_up, btn_down} = m;
    endtask

    task automatic press(input logic [3:0] m);
        @(negedge clk);
        drive(m);
        @(negedge clk);
        drive(4'h0);
    endtask

    task automatic commit(input logic [19:0] e);
        sb_q.push_back(e);
        last_set = e;
        press(MODE);
        chk("field_commit", edit_field, 0);
        @(negedge clk);
        chk("ow_fall", time_ow, 0);
        chk("set_hold", time_set, e);
    endtask

    initial begin
        int c0;
        time_cur = pk(8'h12, 8'h34, 8'h56);
        drive(4'hF);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_field", edit_field, 0);
        chk("rst_ow_cnt", ow_cnt, 0);
        chk("rst_set", time_set, 0);
        chk("rst_disp", time_disp, pk(8'h12, 8'h34, 8'h56));
        time_cur = pk(8'h01, 8'h02, 8'h03);
        drive(4'h0);
        @(negedge clk);
        chk("idle_track", time_disp, pk(8'h01, 8'h02, 8'h03));

        // Full edit from 23:59:58
        time_cur = pk(8'h23, 8'h59, 8'h58);
        press(MODE);
        chk("fe_f1", edit_field, 1);
        chk("fe_cap", time_disp, pk(8'h23, 8'h59, 8'h58));
        press(UP);
        chk("fe_hwrap", hr(time_disp), 8'h00);
        press(MODE);
        chk("fe_f2", edit_field, 2);
        press(DN);
        chk("fe_mdn", mn(time_disp), 8'h58);
        press(MODE);
        chk("fe_f3", edit_field, 3);
        press(UP);
        chk("fe_sup", sc(time_disp), 8'h59);
        commit(pk(8'h00, 8'h58, 8'h59));

        // BCD wraps, first capture
        time_cur = pk(8'h19, 8'h40, 8'h59);
        press(MODE);
        press(UP);
        chk("h19_up", hr(time_disp), 8'h20);
        press(DN);
        chk("h20_dn", hr(time_disp), 8'h19);
        press(MODE);
        press(DN);
        chk("m40_dn", mn(time_disp), 8'h39);
        press(MODE);
        press(UP);
        chk("s59_up", sc(time_disp), 8'h00);
        commit(pk(8'h19, 8'h39, 8'h00));

        // BCD wraps, second capture, ends in cancel
        time_cur = pk(8'h09, 8'h00, 8'h00);
        press(MODE);
        press(UP);
        chk("h09_up", hr(time_disp), 8'h10);
        press(DN);
        chk("h10_dn", hr(time_disp), 8'h09);
        repeat (9) press(DN);
        chk("h_dn9", hr(time_disp), 8'h00);
        press(DN);
        chk("h00_dn", hr(time_disp), 8'h23);
        press(UP);
        chk("h23_up", hr(time_disp), 8'h00);
        press(MODE);
        press(DN);
        chk("m00_dn", mn(time_disp), 8'h59);
        press(UP);
        chk("m59_up", mn(time_disp), 8'h00);
        press(MODE);
        press(DN);
        chk("s00_dn", sc(time_disp), 8'h59);
        c0 = ow_cnt;
        press(CAN);
        chk("can_sec_f", edit_field, 0);
        repeat (2) @(negedge clk);
        chk("can_sec_ow", ow_cnt, c0);
        chk("can_sec_set", time_set, last_set);

        // Capture sanitising
        time_cur = pk(8'h2A, 8'h7F, 8'h35);
        press(MODE);
        chk("san1", time_disp, pk(8'h00, 8'h00, 8'h35));
        press(CAN);
        time_cur = pk(8'h24, 8'h17, 8'h60);
        press(MODE);
        chk("san2", time_disp, pk(8'h00, 8'h17, 8'h00));
        press(CAN);

        // Cancel in MIN
        time_cur = pk(8'h05, 8'h06, 8'h07);
        press(MODE);
        press(MODE);
        press(UP);
        c0 = ow_cnt;
        press(CAN);
        chk("can_min_f", edit_field, 0);
        chk("can_min_disp", time_disp, pk(8'h05, 8'h06, 8'h07));
        repeat (2) @(negedge clk);
        chk("can_min_ow", ow_cnt, c0);
        chk("can_min_set", time_set, last_set);

        // Timeout after 16 idle cycles in HOUR
        press(MODE);
        repeat (14) @(negedge clk);
        chk("tmo_before", edit_field, 1);
        repeat (2) @(negedge clk);
        chk("tmo_after", edit_field, 0);
        chk("tmo_ow", ow_cnt, c0);

        // Simultaneous presses and held button
        time_cur = pk(8'h11, 8'h22, 8'h33);
        press(MODE);
        press(UP | DN);
        chk("updn", hr(time_disp), 8'h11);
        @(negedge clk);
        drive(UP);
        repeat (5) @(negedge clk);
        drive(4'h0);
        chk("held", hr(time_disp), 8'h12);
        press(MODE | UP);
        chk("modeup_f", edit_field, 2);
        chk("modeup_h", hr(time_disp), 8'h12);
        press(MODE);
        c0 = ow_cnt;
        press(CAN | MODE);
        chk("canmode_f", edit_field, 0);
        repeat (2) @(negedge clk);
        chk("canmode_ow", ow_cnt, c0);
        chk("canmode_set", time_set, last_set);

        // Reset mid-edit
        press(MODE);
        chk("pre_rst_f", edit_field, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_f", edit_field, 0);
        chk("rst_mid_ow", time_ow, 0);
        chk("rst_mid_set", time_set, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        chk("ow_total", ow_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
